bmem_arbiter: RTL and testbench
===============================

// Module: bmem_arbiter
// PURPOSE
// - Shares the single banked-memory port between I-cache (line reads) and D-cache (line reads, writebacks).
// - Sits between the two cache miss interfaces and bmem_*; one transaction outstanding at a time.
// - Converts 256-bit line requests into 4-beat 64-bit bursts.
// - Arbitrates simultaneous misses round-robin.
// PARAMETERS
// ADDR_W     32   address width (cache and bmem)
// LINE_W     256  cache line width
// BEAT_W     64   bmem data beat width
// BURST_LEN  4    beats per line (LINE_W/BEAT_W)
// PORTS
// clk           in   1       clock
// rst           in   1       reset, synchronous, active-low (0 = reset)
// icache_addr   in   ADDR_W  I-cache line address
// icache_read   in   1       I-cache read request, held until icache_resp
// icache_rdata  out  LINE_W  I-cache fill line
// icache_resp   out  1       1-cycle completion pulse
// dcache_addr   in   ADDR_W  D-cache line address
// dcache_read   in   1       D-cache read request, held until dcache_resp
// dcache_write  in   1       D-cache writeback request, held until dcache_resp
// dcache_wdata  in   LINE_W  writeback line
// dcache_rdata  out  LINE_W  D-cache fill line
// dcache_resp   out  1       1-cycle completion pulse (reads and writes)
// bmem_addr     out  ADDR_W  burst address, low 5 bits forced 0
// bmem_read     out  1       read command
// bmem_write    out  1       write beat valid
// bmem_wdata    out  BEAT_W  write beat data
// bmem_ready    in   1       memory accepts command/beat this cycle
// bmem_raddr    in   ADDR_W  address tag of returning beat
// bmem_rdata    in   BEAT_W  returning read beat
// bmem_rvalid   in   1       read beat valid
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - state=IDLE, beat_cnt=0.
//   - All outputs 0, incl. *_rdata.
//   - rr_ptr=ICACHE, so I-cache wins the first tie.
//   - Reset mid-burst abandons the transaction; bmem_read/bmem_write are 0 from the next cycle.
// - FSM: IDLE -> RD_REQ -> RD_WAIT -> DONE -> IDLE; IDLE -> WR_BURST -> DONE -> IDLE.
// - IDLE:
//   - Sample requests and latch the granted addr (low 5 bits cleared), wdata and requester ID.
//   - Both requesting: grant rr_ptr's side; rr_ptr flips to the other side on every grant.
//   - dcache_write wins over dcache_read if both are high.
// - RD_REQ:
//   - bmem_read=1, bmem_addr=latched addr.
//   - Held until a cycle with bmem_ready=1, then -> RD_WAIT.
// - RD_WAIT:
//   - Each cycle with bmem_rvalid=1 and bmem_raddr==latched addr: write beat into line[BEAT_W*beat_cnt +: BEAT_W], beat_cnt++.
//   - Beats with mismatched raddr are dropped.
//   - After the 4th beat -> DONE.
// - WR_BURST:
//   - bmem_write=1, bmem_addr=latched addr, bmem_wdata=wline[BEAT_W*beat_cnt +: BEAT_W].
//   - beat_cnt++ only in cycles with bmem_ready=1; when ready=0 the beat is held.
//   - The write is asserted on consecutive cycles until beat 3 is accepted, then -> DONE.
// - DONE:
//   - Granted *_resp=1 for exactly one cycle; the fill line is visible on *_rdata in the same cycle (writes: rdata unchanged).
//   - beat_cnt reset to 0; -> IDLE.
// - *_rdata hold their last fill until that requester's next read completes.
// - Non-granted requester outputs resp=0; its request stays pending and is re-arbitrated in IDLE.
// - Latency, ready always 1:
//   - Read: grant-to-resp = 2 + rvalid arrival cycles.
//   - Write: IDLE sample to resp = 6 cycles (IDLE, 4 beats, DONE).
// - Requests must be deasserted the cycle after resp. A request still high in IDLE is treated as new.
// - bmem_read and bmem_write are never high together.
// - Request changes while not in IDLE are ignored; latched values are used.
// TESTING
// - Reset: rst=0 for 2 cycles with both caches requesting -> all outputs 0; first grant after release goes to icache.
// - I-read addr 0x1234_5678, ready=1, beats 0x11..,0x22..,0x33..,0x44.. on raddr 0x1234_5660
//   -> bmem_addr=0x1234_5660; icache_rdata={0x44..,0x33..,0x22..,0x11..}; one resp pulse.
// - D-write 0xA000_0040, ready toggling 1,0,1,1,0,1 -> exactly 4 beats accepted, in order, data held while ready=0; dcache_resp after 4th.
// - icache_read and dcache_read same cycle, both re-request 3 times -> grants alternate I,D,I,D,I,D; no starvation.
// - RD_WAIT with a stray rvalid on raddr 0xDEAD_BEE0 -> beat ignored, beat_cnt unchanged, correct line delivered.
// - rst=0 asserted on the 2nd write beat -> bmem_write=0 next cycle, no resp; a fresh read after reset completes normally.

Source files
------------

// File: rtl/bmem_arbiter_if.sv
// Cache-miss and banked-memory signal bundle for bmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the caches plus memory side.
interface bmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
);
    logic [ADDR_W-1:0] icache_addr;
    logic              icache_read;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;

    logic [ADDR_W-1:0] dcache_addr;
    logic              dcache_read;
    logic              dcache_write;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  icache_addr, icache_read,
        output icache_rdata, icache_resp,
        input  dcache_addr, dcache_read, dcache_write, dcache_wdata,
        output dcache_rdata, dcache_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output icache_addr, icache_read,
        input  icache_rdata, icache_resp,
        output dcache_addr, dcache_read, dcache_write, dcache_wdata,
        input  dcache_rdata, dcache_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/bmem_arbiter.sv
// Shares the banked-memory port between I-cache and D-cache misses, one line
// transaction at a time, splitting each line into a burst of beats; ties are broken round-robin.
module bmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned BEAT_W    = 64,
    parameter int unsigned BURST_LEN = 4
) (
    input logic           clk,
    input logic           rst,
    bmem_arbiter_if.slave bus
);
    localparam int unsigned       CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned       LINE_BYTES = LINE_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_MASK  = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR_BURST = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_e;

    state_e            state_q,        state_d;
    logic [CNT_W-1:0]  beat_cnt_q,     beat_cnt_d;
    req_e              rr_ptr_q,       rr_ptr_d;
    req_e              owner_q,        owner_d;
    logic              is_wr_q,        is_wr_d;
    logic [ADDR_W-1:0] addr_q,         addr_d;
    logic [LINE_W-1:0] line_q,         line_d;

    logic [LINE_W-1:0] icache_rdata_q, icache_rdata_d;
    logic              icache_resp_q,  icache_resp_d;
    logic [LINE_W-1:0] dcache_rdata_q, dcache_rdata_d;
    logic              dcache_resp_q,  dcache_resp_d;
    logic [ADDR_W-1:0] bmem_addr_q,    bmem_addr_d;
    logic              bmem_read_q,    bmem_read_d;
    logic              bmem_write_q,   bmem_write_d;
    logic [BEAT_W-1:0] bmem_wdata_q,   bmem_wdata_d;

    logic i_req_c;
    logic d_req_c;
    req_e grant_c;

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        is_wr_d        = is_wr_q;
        addr_d         = addr_q;
        line_d         = line_q;
        icache_rdata_d = icache_rdata_q;
        dcache_rdata_d = dcache_rdata_q;
        icache_resp_d  = 1'b0;
        dcache_resp_d  = 1'b0;
        bmem_addr_d    = '0;
        bmem_read_d    = 1'b0;
        bmem_write_d   = 1'b0;
        bmem_wdata_d   = '0;

        i_req_c = bus.icache_read;
        d_req_c = bus.dcache_read | bus.dcache_write;
        grant_c = (i_req_c && d_req_c) ? rr_ptr_q : (i_req_c ? REQ_I : REQ_D);

        case (state_q)
            S_IDLE: begin
                if (i_req_c || d_req_c) begin
                    owner_d    = grant_c;
                    rr_ptr_d   = (grant_c == REQ_I) ? REQ_D : REQ_I;
                    beat_cnt_d = '0;
                    if (grant_c == REQ_I) begin
                        addr_d  = bus.icache_addr & ADDR_MASK;
                        is_wr_d = 1'b0;
                        state_d = S_RD_REQ;
                    end else begin
                        addr_d  = bus.dcache_addr & ADDR_MASK;
                        is_wr_d = bus.dcache_write;
                        if (bus.dcache_write) begin
                            line_d  = bus.dcache_wdata;
                            state_d = S_WR_BURST;
                        end else begin
                            state_d = S_RD_REQ;
                        end
                    end
                end
            end

            S_RD_REQ: begin
                if (bus.bmem_ready) state_d = S_RD_WAIT;
            end

            // Beats tagged with another address belong to someone else and are dropped.
            S_RD_WAIT: begin
                if (bus.bmem_rvalid && (bus.bmem_raddr == addr_q)) begin
                    for (int unsigned b = 0; b < BURST_LEN; b++) begin
                        if (beat_cnt_q == CNT_W'(b)) line_d[b*BEAT_W +: BEAT_W] = bus.bmem_rdata;
                    end
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) state_d = S_DONE;
                end
            end

            S_WR_BURST: begin
                if (bus.bmem_ready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) state_d = S_DONE;
                end
            end

            S_DONE: begin
                beat_cnt_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                beat_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        bmem_read_d  = (state_d == S_RD_REQ);
        bmem_write_d = (state_d == S_WR_BURST);
        if (bmem_read_d || bmem_write_d) bmem_addr_d = addr_d;
        if (bmem_write_d) begin
            for (int unsigned b = 0; b < BURST_LEN; b++) begin
                if (beat_cnt_d == CNT_W'(b)) bmem_wdata_d = line_d[b*BEAT_W +: BEAT_W];
            end
        end

        // Completion pulse and fill line appear together in the DONE cycle.
        if (state_d == S_DONE) begin
            if (owner_d == REQ_I) begin
                icache_resp_d = 1'b1;
                if (!is_wr_d) icache_rdata_d = line_d;
            end else begin
                dcache_resp_d = 1'b1;
                if (!is_wr_d) dcache_rdata_d = line_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            beat_cnt_q     <= '0;
            rr_ptr_q       <= REQ_I;
            owner_q        <= REQ_I;
            is_wr_q        <= 1'b0;
            addr_q         <= '0;
            line_q         <= '0;
            icache_rdata_q <= '0;
            icache_resp_q  <= 1'b0;
            dcache_rdata_q <= '0;
            dcache_resp_q  <= 1'b0;
            bmem_addr_q    <= '0;
            bmem_read_q    <= 1'b0;
            bmem_write_q   <= 1'b0;
            bmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            is_wr_q        <= is_wr_d;
            addr_q         <= addr_d;
            line_q         <= line_d;
            icache_rdata_q <= icache_rdata_d;
            icache_resp_q  <= icache_resp_d;
            dcache_rdata_q <= dcache_rdata_d;
            dcache_resp_q  <= dcache_resp_d;
            bmem_addr_q    <= bmem_addr_d;
            bmem_read_q    <= bmem_read_d;
            bmem_write_q   <= bmem_write_d;
            bmem_wdata_q   <= bmem_wdata_d;
        end
    end

    assign bus.icache_rdata = icache_rdata_q;
    assign bus.icache_resp  = icache_resp_q;
    assign bus.dcache_rdata = dcache_rdata_q;
    assign bus.dcache_resp  = dcache_resp_q;
    assign bus.bmem_addr    = bmem_addr_q;
    assign bus.bmem_read    = bmem_read_q;
    assign bus.bmem_write   = bmem_write_q;
    assign bus.bmem_wdata   = bmem_wdata_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: randomized cache requests and a memory responder,
// checked against line/beat expectations built from the burst and arbitration rules.
module tb_bmem_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEAT_W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

    bmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests;
    int n_fail;
    int cyc;
    int both_high;
    int i_rereq;
    int d_rereq;
    bit d_is_wr;
    bit use_fixed;
    logic [63:0] fixed_beats [4];
    logic [255:0] last_i_fill;
    logic [255:0] last_d_fill;

    logic [31:0]  rd_cmd_q     [$];
    int           rd_cmd_cyc_q [$];
    logic [255:0] rd_sent_q    [$];
    logic [31:0]  wr_addr_q    [$];
    logic [63:0]  wr_data_q    [$];
    bit           wr_acc_q     [$];
    int           wr_cyc_q     [$];
    bit           resp_side_q  [$];
    logic [255:0] resp_data_q  [$];
    int           resp_cyc_q   [$];
    bit           rdy_pat      [$];

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic clear_logs();
        rd_cmd_q.delete(); rd_cmd_cyc_q.delete(); rd_sent_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_acc_q.delete(); wr_cyc_q.delete();
        resp_side_q.delete(); resp_data_q.delete(); resp_cyc_q.delete(); rdy_pat.delete();
        both_high = 0; use_fixed = 1'b0; i_rereq = 0; d_rereq = 0; d_is_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.icache_read = 1'b0; bus.dcache_read = 1'b0; bus.dcache_write = 1'b0;
        bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_i_fill = '0; last_d_fill = '0;
    endtask

    // Caches and memory stand-in: drops requests after resp, optionally re-requests,
    // returns 4 beats per accepted read, logs every write cycle and every completion.
    task automatic serve(input int max_cyc, input int rdy_pct, input int rv_pct,
                         input int stray_pct, output bit timed_out);
        int pend; int i_gap; int d_gap; int quiet;
        logic [31:0] tag;
        logic [63:0] beats [4];
        pend = 0; i_gap = 0; d_gap = 0; quiet = 0; tag = '0; timed_out = 1'b1;
        for (int b = 0; b < 4; b++) beats[b] = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            cyc++;
            if (bus.bmem_read && bus.bmem_write) both_high++;
            if (bus.icache_resp) begin
                resp_side_q.push_back(1'b0); resp_data_q.push_back(bus.icache_rdata); resp_cyc_q.push_back(cyc);
                bus.icache_read = 1'b0; i_gap = 2;
            end else if (i_gap > 0) begin
                i_gap--;
                if (i_gap == 0 && i_rereq > 0) begin i_rereq--; bus.icache_read = 1'b1; end
            end
            if (bus.dcache_resp) begin
                resp_side_q.push_back(1'b1); resp_data_q.push_back(bus.dcache_rdata); resp_cyc_q.push_back(cyc);
                bus.dcache_read = 1'b0; bus.dcache_write = 1'b0; d_gap = 2;
            end else if (d_gap > 0) begin
                d_gap--;
                if (d_gap == 0 && d_rereq > 0) begin
                    d_rereq--;
                    if (d_is_wr) bus.dcache_write = 1'b1; else bus.dcache_read = 1'b1;
                end
            end
            bus.bmem_rvalid = 1'b0; bus.bmem_raddr = $urandom; bus.bmem_rdata = {$urandom, $urandom};
            if (pend > 0 && int'($urandom_range(99)) < rv_pct) begin
                bus.bmem_rvalid = 1'b1; bus.bmem_raddr = tag; bus.bmem_rdata = beats[4-pend]; pend--;
            end else if (int'($urandom_range(99)) < stray_pct) begin
                bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'hDEAD_BEE0;
            end
            if (rdy_pat.size() > 0 && bus.bmem_write) bus.bmem_ready = rdy_pat.pop_front();
            else bus.bmem_ready = (int'($urandom_range(99)) < rdy_pct);
            if (bus.bmem_read && bus.bmem_ready) begin
                tag = bus.bmem_addr;
                for (int b = 0; b < 4; b++) beats[b] = use_fixed ? fixed_beats[b] : {$urandom, $urandom};
                rd_cmd_q.push_back(tag); rd_cmd_cyc_q.push_back(cyc);
                rd_sent_q.push_back({beats[3], beats[2], beats[1], beats[0]});
                pend = 4;
            end
            if (bus.bmem_write) begin
                wr_addr_q.push_back(bus.bmem_addr); wr_data_q.push_back(bus.bmem_wdata);
                wr_acc_q.push_back(bus.bmem_ready); wr_cyc_q.push_back(cyc);
            end
            if (!bus.icache_read && !bus.dcache_read && !bus.dcache_write && i_gap == 0 && d_gap == 0
                && pend == 0 && !bus.bmem_read && !bus.bmem_write) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        bit to;
        clear_logs();
        rst = 1'b0;
        bus.icache_addr = 32'h0000_1000; bus.icache_read = 1'b1;
        bus.dcache_addr = 32'h8000_2000; bus.dcache_read = 1'b1; bus.dcache_write = 1'b0;
        bus.dcache_wdata = '0; bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr = '0; bus.bmem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.icache_resp, bus.dcache_resp, bus.bmem_read, bus.bmem_write} !== 4'b0) begin
                n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.icache_resp, bus.dcache_resp, bus.bmem_read, bus.bmem_write});
            end
            n_tests++;
            if (bus.icache_rdata !== '0 || bus.dcache_rdata !== '0 || bus.bmem_addr !== '0 || bus.bmem_wdata !== '0) begin
                n_fail++; $display("FAIL reset_data: got addr %h wdata %h, expected all zero", bus.bmem_addr, bus.bmem_wdata);
            end
        end
        rst = 1'b1; last_i_fill = '0; last_d_fill = '0;
        serve(400, 100, 100, 0, to);
        n_tests++;
        if (to || resp_side_q.size() != 2 || rd_cmd_q.size() != 2) begin
            n_fail++; $display("FAIL reset_release: timeout %0d resps %0d cmds %0d expected 0 2 2", to, resp_side_q.size(), rd_cmd_q.size());
        end else begin
            n_tests++;
            if (rd_cmd_q[0] !== 32'h0000_1000 || resp_side_q[0] !== 1'b0) begin
                n_fail++; $display("FAIL first_grant: got addr %h side %0d expected 00001000 side 0", rd_cmd_q[0], resp_side_q[0]);
            end
            last_i_fill = rd_sent_q[0]; last_d_fill = rd_sent_q[1];
        end
    endtask

    task automatic test_iread();
        bit to;
        logic [255:0] exp_line;
        clear_logs();
        use_fixed = 1'b1;
        fixed_beats[0] = 64'h1111_1111_1111_1111; fixed_beats[1] = 64'h2222_2222_2222_2222;
        fixed_beats[2] = 64'h3333_3333_3333_3333; fixed_beats[3] = 64'h4444_4444_4444_4444;
        exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        bus.icache_addr = 32'h1234_5678; bus.icache_read = 1'b1;
        serve(200, 100, 100, 0, to);
        n_tests++;
        if (to || rd_cmd_q.size() != 1 || resp_side_q.size() != 1) begin
            n_fail++; $display("FAIL iread_count: timeout %0d cmds %0d resps %0d expected 0 1 1", to, rd_cmd_q.size(), resp_side_q.size());
        end else begin
            n_tests++;
            if (rd_cmd_q[0] !== 32'h1234_5660) begin
                n_fail++; $display("FAIL iread_addr: got %h expected 12345660", rd_cmd_q[0]);
            end
            n_tests++;
            if (resp_side_q[0] !== 1'b0 || resp_data_q[0] !== exp_line) begin
                n_fail++; $display("FAIL iread_line: side %0d got %h expected %h", resp_side_q[0], resp_data_q[0], exp_line);
            end
            n_tests++;
            if (resp_cyc_q[0] - rd_cmd_cyc_q[0] != 5) begin
                n_fail++; $display("FAIL iread_latency: got %0d expected 5", resp_cyc_q[0] - rd_cmd_cyc_q[0]);
            end
        end
        last_i_fill = exp_line;
    endtask

    task automatic test_dwrite();
        bit to; int k;
        logic [255:0] wline;
        clear_logs();
        wline = rand_line();
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        d_is_wr = 1'b1;
        bus.dcache_addr = 32'hA000_0040; bus.dcache_wdata = wline;
        bus.dcache_write = 1'b1; bus.dcache_read = 1'b1;
        serve(200, 100, 100, 0, to);
        n_tests++;
        if (to || rd_cmd_q.size() != 0 || wr_acc_q.size() != 6) begin
            n_fail++; $display("FAIL dwrite_shape: timeout %0d reads %0d write cycles %0d expected 0 0 6", to, rd_cmd_q.size(), wr_acc_q.size());
        end
        k = 0;
        for (int i = 0; i < wr_acc_q.size() && k < 4; i++) begin
            n_tests++;
            if (wr_addr_q[i] !== 32'hA000_0040 || wr_data_q[i] !== wline[64*k +: 64]) begin
                n_fail++; $display("FAIL dwrite_beat%0d: got %h/%h expected a0000040/%h", i, wr_addr_q[i], wr_data_q[i], wline[64*k +: 64]);
            end
            if (wr_acc_q[i]) k++;
        end
        n_tests++;
        if (k != 4 || resp_side_q.size() != 1) begin
            n_fail++; $display("FAIL dwrite_accepts: got %0d beats %0d resps expected 4 1", k, resp_side_q.size());
        end else begin
            n_tests++;
            if (resp_side_q[0] !== 1'b1 || resp_data_q[0] !== last_d_fill || resp_cyc_q[0] - wr_cyc_q[wr_cyc_q.size()-1] != 1) begin
                n_fail++; $display("FAIL dwrite_resp: side %0d gap %0d rdata %h expected side 1 gap 1 rdata %h",
                                   resp_side_q[0], resp_cyc_q[0] - wr_cyc_q[wr_cyc_q.size()-1], resp_data_q[0], last_d_fill);
            end
        end
    endtask

    task automatic test_round_robin();
        bit to;
        logic [31:0] ia; logic [31:0] da;
        do_reset();
        clear_logs();
        ia = {1'b0, 31'($urandom)} & ~32'h1F; da = {1'b1, 31'($urandom)} & ~32'h1F;
        bus.icache_addr = ia | 32'h7; bus.dcache_addr = da | 32'h19;
        i_rereq = 2; d_rereq = 2;
        bus.icache_read = 1'b1; bus.dcache_read = 1'b1;
        serve(2000, 70, 70, 10, to);
        n_tests++;
        if (to || resp_side_q.size() != 6 || rd_sent_q.size() != 6) begin
            n_fail++; $display("FAIL rr_count: timeout %0d resps %0d expected 0 6", to, resp_side_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (resp_side_q[i] !== 1'(i % 2) || rd_cmd_q[i] !== ((i % 2 == 0) ? ia : da) || resp_data_q[i] !== rd_sent_q[i]) begin
                    n_fail++; $display("FAIL rr_grant%0d: side %0d addr %h expected side %0d", i, resp_side_q[i], rd_cmd_q[i], i % 2);
                end
            end
            last_i_fill = rd_sent_q[4]; last_d_fill = rd_sent_q[5];
        end
        n_tests++;
        if (both_high != 0) begin
            n_fail++; $display("FAIL rr_exclusive: got %0d cycles with read and write expected 0", both_high);
        end
    endtask

    task automatic test_stray();
        bit to;
        clear_logs();
        bus.icache_addr = {1'b0, 31'($urandom)}; bus.icache_read = 1'b1;
        serve(600, 80, 40, 70, to);
        n_tests++;
        if (to || resp_side_q.size() != 1 || rd_sent_q.size() != 1) begin
            n_fail++; $display("FAIL stray_count: timeout %0d resps %0d expected 0 1", to, resp_side_q.size());
        end else begin
            n_tests++;
            if (resp_data_q[0] !== rd_sent_q[0] || rd_cmd_q[0] !== (bus.icache_addr & ~32'h1F)) begin
                n_fail++; $display("FAIL stray_line: got %h expected %h", resp_data_q[0], rd_sent_q[0]);
            end
            last_i_fill = rd_sent_q[0];
        end
    endtask

    task automatic test_reset_midburst();
        bit to; bit seen; int acc; int bad;
        clear_logs();
        d_is_wr = 1'b1;
        bus.dcache_addr = $urandom; bus.dcache_wdata = rand_line(); bus.dcache_write = 1'b1;
        bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0;
        seen = 1'b0; acc = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.bmem_write) begin
                if (acc == 1) begin seen = 1'b1; rst = 1'b0; end
                else acc++;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL midburst_start: got no second write beat expected one within 50 cycles");
        end
        @(negedge clk);
        bus.dcache_write = 1'b0;
        n_tests++;
        if (bus.bmem_write !== 1'b0 || bus.bmem_read !== 1'b0 || bus.dcache_resp !== 1'b0 || bus.dcache_rdata !== '0) begin
            n_fail++; $display("FAIL midburst_abort: got write %b read %b resp %b expected 0 0 0", bus.bmem_write, bus.bmem_read, bus.dcache_resp);
        end
        rst = 1'b1; last_i_fill = '0; last_d_fill = '0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.dcache_resp || bus.icache_resp || bus.bmem_write || bus.bmem_read) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL midburst_quiet: got %0d active cycles expected 0", bad);
        end
        bus.icache_addr = $urandom; bus.icache_read = 1'b1;
        serve(300, 90, 80, 0, to);
        n_tests++;
        if (to || resp_side_q.size() != 1 || rd_sent_q.size() != 1) begin
            n_fail++; $display("FAIL midburst_fresh: timeout %0d resps %0d expected 0 1", to, resp_side_q.size());
        end else begin
            n_tests++;
            if (resp_side_q[0] !== 1'b0 || resp_data_q[0] !== rd_sent_q[0]) begin
                n_fail++; $display("FAIL midburst_line: got %h expected %h", resp_data_q[0], rd_sent_q[0]);
            end
            last_i_fill = rd_sent_q[0];
        end
    endtask

    task automatic test_random();
        bit to; bit side; bit wr; int rdy; int k;
        logic [31:0] a; logic [255:0] wline;
        for (int t = 0; t < 16; t++) begin
            clear_logs();
            side = 1'($urandom_range(1)); wr = side & 1'($urandom_range(1));
            a = {1'b0, 31'($urandom)}; wline = rand_line();
            rdy = ($urandom_range(3) == 0) ? 100 : int'($urandom_range(99, 30));
            d_is_wr = wr;
            if (!side) begin bus.icache_addr = a; bus.icache_read = 1'b1; end
            else begin
                bus.dcache_addr = a; bus.dcache_wdata = wline;
                bus.dcache_write = wr; bus.dcache_read = ~wr | 1'($urandom_range(1));
            end
            serve(600, rdy, int'($urandom_range(100, 40)), int'($urandom_range(30)), to);
            n_tests++;
            if (to || resp_side_q.size() != 1 || resp_side_q[0] !== side) begin
                n_fail++; $display("FAIL rand%0d_resp: timeout %0d resps %0d expected 0 1 on side %0d", t, to, resp_side_q.size(), side);
                continue;
            end
            if (wr) begin
                k = 0;
                for (int i = 0; i < wr_acc_q.size() && k < 4; i++) begin
                    n_tests++;
                    if (wr_addr_q[i] !== (a & ~32'h1F) || wr_data_q[i] !== wline[64*k +: 64]) begin
                        n_fail++; $display("FAIL rand%0d_wbeat%0d: got %h/%h expected %h/%h", t, i, wr_addr_q[i], wr_data_q[i], a & ~32'h1F, wline[64*k +: 64]);
                    end
                    if (wr_acc_q[i]) k++;
                end
                n_tests++;
                if (k != 4 || rd_cmd_q.size() != 0 || resp_data_q[0] !== last_d_fill) begin
                    n_fail++; $display("FAIL rand%0d_write: got %0d beats %0d reads expected 4 0, rdata held", t, k, rd_cmd_q.size());
                end
                if (rdy == 100) begin
                    n_tests++;
                    if (resp_cyc_q[0] - wr_cyc_q[0] != 4) begin
                        n_fail++; $display("FAIL rand%0d_wlatency: got %0d expected 4", t, resp_cyc_q[0] - wr_cyc_q[0]);
                    end
                end
            end else begin
                n_tests++;
                if (rd_cmd_q.size() != 1 || rd_cmd_q[0] !== (a & ~32'h1F) || resp_data_q[0] !== rd_sent_q[0]) begin
                    n_fail++; $display("FAIL rand%0d_read: cmds %0d got %h expected line built from sent beats", t, rd_cmd_q.size(), resp_data_q[0]);
                end else if (side) last_d_fill = rd_sent_q[0];
                else last_i_fill = rd_sent_q[0];
            end
            n_tests++;
            if (both_high != 0) begin
                n_fail++; $display("FAIL rand%0d_exclusive: got %0d overlap cycles expected 0", t, both_high);
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        last_i_fill = '0; last_d_fill = '0;
        test_reset();
        test_iread();
        test_dwrite();
        test_round_robin();
        test_stray();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
